// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rob_pkg
// Brief    : Op-type codes and default widths shared by the reorder buffer.
// Revision : 1.0
// ============================================================================
package rob_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [OP_W-1:0] OP_ARITH  = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'd1;
    localparam logic [OP_W-1:0] OP_STORE  = 3'd2;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd3;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : reorder_buffer_if
// Brief     : Dispatch, lookup, writeback and commit signals of the ROB.
// Revision  : 1.0
// ============================================================================
interface reorder_buffer_if #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int DATA_W   = rob_pkg::DATA_W,
    parameter int REG_W    = rob_pkg::REG_W,
    parameter int OP_W     = rob_pkg::OP_W,
    parameter int WB_PORTS = 2
);
    logic                         alloc_valid_in;
    logic [OP_W-1:0]              alloc_op_in;
    logic [REG_W-1:0]             alloc_dest_in;
    logic                         alloc_ready_out;
    logic [IDX_W-1:0]             alloc_id_out;

    logic [IDX_W-1:0]             rs1_id_in;
    logic [IDX_W-1:0]             rs2_id_in;
    logic                         rs1_rdy_out;
    logic                         rs2_rdy_out;
    logic [DATA_W-1:0]            rs1_val_out;
    logic [DATA_W-1:0]            rs2_val_out;

    logic [WB_PORTS-1:0]          wb_valid_in;
    logic [WB_PORTS*IDX_W-1:0]    wb_id_in;
    logic [WB_PORTS*DATA_W-1:0]   wb_val_in;

    logic                         commit_ready_in;
    logic                         commit_valid_out;
    logic [OP_W-1:0]              commit_op_out;
    logic [REG_W-1:0]             commit_dest_out;
    logic [DATA_W-1:0]            commit_val_out;
    logic [IDX_W-1:0]             commit_id_out;
    logic [IDX_W:0]               count_out;

    modport slave (
        input  alloc_valid_in, alloc_op_in, alloc_dest_in,
        output alloc_ready_out, alloc_id_out,
        input  rs1_id_in, rs2_id_in,
        output rs1_rdy_out, rs2_rdy_out, rs1_val_out, rs2_val_out,
        input  wb_valid_in, wb_id_in, wb_val_in,
        input  commit_ready_in,
        output commit_valid_out, commit_op_out, commit_dest_out,
        output commit_val_out, commit_id_out, count_out
    );

    modport master (
        output alloc_valid_in, alloc_op_in, alloc_dest_in,
        input  alloc_ready_out, alloc_id_out,
        output rs1_id_in, rs2_id_in,
        input  rs1_rdy_out, rs2_rdy_out, rs1_val_out, rs2_val_out,
        output wb_valid_in, wb_id_in, wb_val_in,
        output commit_ready_in,
        input  commit_valid_out, commit_op_out, commit_dest_out,
        input  commit_val_out, commit_id_out, count_out
    );

endinterface
`default_nettype wire

// File: rtl/rob_lookup.sv
`default_nettype none
// ============================================================================
// Module   : rob_lookup
// Brief    : One operand read port; ROB_BYPASS_EN adds same-cycle writeback bypass.
// Revision : 1.0
// ============================================================================
module rob_lookup #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 2
) (
    input  wire logic [IDX_W-1:0]           id_in,
    input  wire logic [DEPTH-1:0]           busy_in,
    input  wire logic [DEPTH-1:0]           done_in,
    input  wire logic [DATA_W-1:0]          val_in [DEPTH],
    input  wire logic [WB_PORTS-1:0]        wb_valid_in,
    input  wire logic [WB_PORTS*IDX_W-1:0]  wb_id_in,
    input  wire logic [WB_PORTS*DATA_W-1:0] wb_val_in,
    output logic                            rdy_out,
    output logic [DATA_W-1:0]               val_out
);

`ifdef ROB_BYPASS_EN
    // Walk ports high to low so the lowest-numbered matching port ends up selected.
    always_comb begin
        rdy_out = busy_in[id_in] & done_in[id_in];
        val_out = val_in[id_in];
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid_in[p] && (wb_id_in[p*IDX_W +: IDX_W] == id_in) && busy_in[id_in]) begin
                rdy_out = 1'b1;
                val_out = wb_val_in[p*DATA_W +: DATA_W];
            end
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid_in, wb_id_in, wb_val_in};

    always_comb begin
        rdy_out = busy_in[id_in] & done_in[id_in];
        val_out = val_in[id_in];
    end
`endif

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : In-order-commit reorder buffer: 1 alloc, WB_PORTS writebacks and
//            1 commit per cycle. Optional macro ROB_BYPASS_EN enables lookup bypass.
// Revision : 1.0
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int DATA_W   = rob_pkg::DATA_W,
    parameter int REG_W    = rob_pkg::REG_W,
    parameter int OP_W     = rob_pkg::OP_W,
    parameter int WB_PORTS = 2
) (
    input  wire logic          clk_in,
    input  wire logic          rst_n_in,
    input  wire logic          rdy_in,
    input  wire logic          flush_in,
    reorder_buffer_if.slave    rob
);
    import rob_pkg::*;

    localparam logic [IDX_W:0] c_full_count = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [OP_W-1:0]   op_d   [DEPTH];
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [REG_W-1:0]  dest_d [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [DATA_W-1:0] val_d  [DEPTH];

    logic              commit_valid_q, commit_valid_d;
    logic [OP_W-1:0]   commit_op_q, commit_op_d;
    logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
    logic [DATA_W-1:0] commit_val_q, commit_val_d;
    logic [IDX_W-1:0]  commit_id_q, commit_id_d;

    logic [IDX_W-1:0]  wb_id  [WB_PORTS];
    logic [DATA_W-1:0] wb_val [WB_PORTS];
    logic              alloc_ready;
    logic              alloc_fire;
    logic              commit_fire;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_unpack
        assign wb_id[p]  = rob.wb_id_in[p*IDX_W +: IDX_W];
        assign wb_val[p] = rob.wb_val_in[p*DATA_W +: DATA_W];
    end

    // Full blocks allocation even when a commit frees an entry in the same cycle.
    assign alloc_ready = (count_q < c_full_count);
    assign alloc_fire  = rob.alloc_valid_in & alloc_ready;
    assign commit_fire = (count_q != '0) & busy_q[head_q] & done_q[head_q] &
                         ((op_q[head_q] != OP_STORE) | rob.commit_ready_in);

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        done_d         = done_q;
        op_d           = op_q;
        dest_d         = dest_q;
        val_d          = val_q;
        commit_valid_d = commit_valid_q;
        commit_op_d    = commit_op_q;
        commit_dest_d  = commit_dest_q;
        commit_val_d   = commit_val_q;
        commit_id_d    = commit_id_q;

        if (rdy_in) begin
            if (flush_in) begin
                busy_d         = '0;
                done_d         = '0;
                head_d         = '0;
                tail_d         = '0;
                count_d        = '0;
                commit_valid_d = 1'b0;
            end else begin
                // Descending walk lets the lowest-numbered port win a shared id.
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (rob.wb_valid_in[p] && busy_q[wb_id[p]]) begin
                        val_d[wb_id[p]]  = wb_val[p];
                        done_d[wb_id[p]] = 1'b1;
                    end
                end

                commit_valid_d = commit_fire;
                if (commit_fire) begin
                    commit_op_d      = op_q[head_q];
                    commit_dest_d    = dest_q[head_q];
                    commit_val_d     = val_q[head_q];
                    commit_id_d      = head_q;
                    busy_d[head_q]   = 1'b0;
                    done_d[head_q]   = 1'b0;
                    head_d           = head_q + 1'b1;
                end

                if (alloc_fire) begin
                    op_d[tail_q]   = rob.alloc_op_in;
                    dest_d[tail_q] = rob.alloc_dest_in;
                    busy_d[tail_q] = 1'b1;
                    done_d[tail_q] = 1'b0;
                    tail_d         = tail_q + 1'b1;
                end

                case ({alloc_fire, commit_fire})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            done_q         <= '0;
            commit_valid_q <= 1'b0;
            commit_op_q    <= '0;
            commit_dest_q  <= '0;
            commit_val_q   <= '0;
            commit_id_q    <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            commit_valid_q <= commit_valid_d;
            commit_op_q    <= commit_op_d;
            commit_dest_q  <= commit_dest_d;
            commit_val_q   <= commit_val_d;
            commit_id_q    <= commit_id_d;
        end
    end

    // Payload storage is qualified by busy/done, so it needs no reset.
    always_ff @(posedge clk_in) begin
        op_q   <= op_d;
        dest_q <= dest_d;
        val_q  <= val_d;
    end

    assign rob.alloc_ready_out  = alloc_ready;
    assign rob.alloc_id_out     = tail_q;
    assign rob.commit_valid_out = commit_valid_q;
    assign rob.commit_op_out    = commit_op_q;
    assign rob.commit_dest_out  = commit_dest_q;
    assign rob.commit_val_out   = commit_val_q;
    assign rob.commit_id_out    = commit_id_q;
    assign rob.count_out        = count_q;

    rob_lookup #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .DATA_W   (DATA_W),
        .WB_PORTS (WB_PORTS)
    ) u_lookup_rs1 (
        .id_in       (rob.rs1_id_in),
        .busy_in     (busy_q),
        .done_in     (done_q),
        .val_in      (val_q),
        .wb_valid_in (rob.wb_valid_in),
        .wb_id_in    (rob.wb_id_in),
        .wb_val_in   (rob.wb_val_in),
        .rdy_out     (rob.rs1_rdy_out),
        .val_out     (rob.rs1_val_out)
    );

    rob_lookup #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .DATA_W   (DATA_W),
        .WB_PORTS (WB_PORTS)
    ) u_lookup_rs2 (
        .id_in       (rob.rs2_id_in),
        .busy_in     (busy_q),
        .done_in     (done_q),
        .val_in      (val_q),
        .wb_valid_in (rob.wb_valid_in),
        .wb_id_in    (rob.wb_id_in),
        .wb_val_in   (rob.wb_val_in),
        .rdy_out     (rob.rs2_rdy_out),
        .val_out     (rob.rs2_val_out)
    );

endmodule
`default_nettype wire
